data_mem_wb: RTL
================

Name: data_mem_wb

Overview:
CPU-side data memory interface with a posted-write buffer, generalised in width and buffer depth. Stores are queued and retire to the bus in the background, so a store costs one cycle while the buffer has room. Loads are served by forwarding from the buffer on an address hit. On a miss, a load waits until the buffer has drained and then issues a bus read. The block sits between the MEM stage and the bus arbiter and uses the same start/done bus handshake as the existing data-memory path.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, address width
WB_DEPTH, 4, write-buffer entries; power of two, >=2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_W  CPU access address
we  in  1  store request
re  in  1  load request
data  in  DATA_W  store data
q  out  DATA_W  load result
busy  out  1  stall request to the pipeline
clear  in  1  pipeline flush; ignored (posted writes are never dropped)
hold  in  1  pipeline hold; gates we/re
drained  out  1  buffer empty and FSM in IDLE (for fences/MMIO)
bus_addr  out  ADDR_W  bus address
bus_data  out  DATA_W  bus write data
bus_we  out  1  bus write strobe
bus_start  out  1  bus request, level
bus_q  in  DATA_W  bus read data
bus_done  in  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count cleared; FSM enters IDLE; qreg=0.
  - Outputs during reset: bus_start=0, bus_we=0, bus_addr=0, bus_data=0, q=0, drained=1, busy=0 unless a request is presented.
  - Reset mid-transaction abandons the bus access; the bus side is reset by the same net.
- Acceptance: acc_we = we & ~hold; acc_re = re & ~hold & ~we. Simultaneous we and re is illegal; we wins.
- Write buffer: circular FIFO of {addr,data}; count width clog2(WB_DEPTH)+1.
  - Store when count<WB_DEPTH: enqueue at the clock edge; busy=0.
  - Store when count==WB_DEPTH: busy=1 and no enqueue, even if a pop occurs in the same cycle. The CPU re-presents the store.
  - Simultaneous push and pop: count unchanged, both pointers advance; wrap at WB_DEPTH.
- Forwarding:
  - Combinational compare of addr against every valid entry; the youngest match wins.
  - Hit on acc_re: q=entry data in the same cycle, busy=0, qreg captures it, no bus access.
  - An entry whose drain completes this cycle is still valid for forwarding this cycle.
- FSM states IDLE, WR, RD:
  - IDLE -> WR when count>0 (evaluated the cycle after an enqueue).
  - IDLE -> RD when count==0 and acc_re misses; rd_addr latches addr.
  - WR: bus_addr/bus_data = FIFO head, bus_we=1. On bus_done: pop the head, then go WR if count>1 (after pop), else IDLE.
  - RD: bus_addr=rd_addr, bus_we=0. On bus_done: q=bus_q combinationally, busy=0, qreg<=bus_q, next state IDLE.
- Bus request: bus_start = (state!=IDLE) & ~bus_done, i.e. it drops combinationally in the done cycle. Address, data and we are stable while bus_start=1. Back-to-back drains have one IDLE-free gap: bus_start re-asserts the next cycle.
- busy:
  - acc_we: busy = full.
  - acc_re: busy = ~(hit | (state==RD & bus_done)).
  - A load miss while WR is active or count>0 stays busy; ordering is preserved.
- q when not completing a load = qreg.
- drained = (count==0) & (state==IDLE), registered-state derived.
- Read latency: hit 0 cycles of stall; miss = drain time + 1 cycle to enter RD + bus latency.

Decomposition:
- Shared package (cpu_mem_pkg):
  - FSM state encoding IDLE=2'd0, WR=2'd1, RD=2'd2.
  - Default DATA_W/ADDR_W constants.
  - Write-buffer entry struct {addr,data}.
- Natural sub-module: wb_fifo. Parametrised circular buffer exposing head, count, full and empty, plus a flat valid-entry array for the forwarding compare. The top level holds the FSM, forwarding and busy logic.

Test Plan:
- Store 0x10<=0xAAAA5555 from idle -> busy=0 that cycle. Next cycle bus_start=1, bus_we=1, bus_addr=0x10. Done after 3 cycles -> drained=1 the following cycle.
- Five back-to-back stores to 0x0,0x4,0x8,0xC,0x20, bus_done held off -> 5th store sees busy=1 until the first pop. Bus writes then occur in program order.
- Stores 0x40<=1 then 0x40<=2, then a load of 0x40 while the bus is stalled -> q=2 in the load cycle, busy=0, no RD bus_start.
- Store 0x80<=7, then load 0x84 (miss) -> busy held through the write drain. Then bus_start with bus_we=0, bus_addr=0x84. bus_q=0x1234 with done -> q=0x1234 that cycle, q stays 0x1234 afterwards.
- hold=1 with we=1 for 3 cycles -> count stays 0, no bus activity.
- Assert reset mid-RD with bus_start=1 -> bus_start=0 asynchronously, q=0, drained=1; a post-reset store works normally.

Source files
------------

// File: rtl/data_mem_wb_pkg.sv
// rtl/data_mem_wb_pkg.sv - shared types and constants for the CPU data-memory path
package cpu_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/data_mem_wb_if.sv
// rtl/data_mem_wb_if.sv - start/done bus between the data-memory path and the arbiter
interface data_mem_wb_if
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_we;
  logic              bus_start;
  logic [DATA_W-1:0] bus_q;
  logic              bus_done;

  modport master (
    output bus_addr, bus_data, bus_we, bus_start,
    input  bus_q, bus_done
  );

  modport slave (
    input  bus_addr, bus_data, bus_we, bus_start,
    output bus_q, bus_done
  );

endinterface

// File: rtl/data_mem_wb_wb_fifo.sv
// rtl/data_mem_wb_wb_fifo.sv - circular posted-write buffer with age-ordered entry view
module wb_fifo
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH*ADDR_W-1:0]    ent_addr,
  output logic [DEPTH*DATA_W-1:0]    ent_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Entry k is the k-th oldest, so the highest valid matching k is the youngest store.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] slot;
    assign slot                          = rd_ptr + PW'(k);
    assign ent_valid[k]                  = (CW'(k) < count);
    assign ent_addr[k*ADDR_W +: ADDR_W]  = addr_mem[slot];
    assign ent_data[k*DATA_W +: DATA_W]  = data_mem[slot];
  end

endmodule

// File: rtl/data_mem_wb.sv
// rtl/data_mem_wb.sv - data-memory interface with posted-write buffer and store forwarding
module data_mem_wb
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  input  logic              clear,
  input  logic              hold,
  output logic              drained,
  data_mem_wb_if.master     bus
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic                       acc_we, acc_re, push, pop, rd_done;
  logic                       full, empty, hit;
  logic [CW-1:0]              count;
  logic [ADDR_W-1:0]          head_addr, rd_addr;
  logic [DATA_W-1:0]          head_data, fwd_data, qreg;
  logic [WB_DEPTH-1:0]        ent_valid;
  logic [WB_DEPTH*ADDR_W-1:0] ent_addr;
  logic [WB_DEPTH*DATA_W-1:0] ent_data;
  logic [1:0]                 state, state_nxt;
  logic                       unused_clear;

  // Posted writes are never dropped, so a flush has nothing to cancel here.
  assign unused_clear = clear;

  assign acc_we  = we & ~hold;
  assign acc_re  = re & ~hold & ~we;
  assign push    = acc_we & ~full;
  assign pop     = (state == ST_WR) & bus.bus_done;
  assign rd_done = (state == ST_RD) & bus.bus_done;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (addr),
    .push_data (data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (ent_valid[k] && ent_addr[k*ADDR_W +: ADDR_W] == addr) begin
        hit      = 1'b1;
        fwd_data = ent_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Entering WR on the enqueue edge starts the drain in the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!empty || push)        state_nxt = ST_WR;
        else if (acc_re && !hit)   state_nxt = ST_RD;
      end
      ST_WR: begin
        if (bus.bus_done) state_nxt = (count > CW'(1) || push) ? ST_WR : ST_IDLE;
      end
      ST_RD: begin
        if (bus.bus_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      qreg    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && empty && acc_re && !hit) rd_addr <= addr;
      if (acc_re && hit)  qreg <= fwd_data;
      else if (rd_done)   qreg <= bus.bus_q;
    end
  end

  assign bus.bus_start = (state != ST_IDLE) & ~bus.bus_done;
  assign bus.bus_we    = (state == ST_WR);
  assign bus.bus_addr  = (state == ST_WR) ? head_addr :
                         (state == ST_RD) ? rd_addr : '0;
  assign bus.bus_data  = (state == ST_WR) ? head_data : '0;

  assign busy    = acc_we ? full : (acc_re ? ~(hit | rd_done) : 1'b0);
  assign q       = (acc_re && hit) ? fwd_data : (rd_done ? bus.bus_q : qreg);
  assign drained = empty & (state == ST_IDLE);

endmodule
